// File: rtl/int_calc_seq.sv
// int_calc_seq: multi-cycle unsigned integer calculator with valid/ready handshakes
// on both sides, iterative mul/div/mod/pow engines and status flags.
// Optional feature macro: INT_CALC_SAT_EN. When it is defined, overflowing add/mul/pow/shl
// results saturate to all ones and a borrowing sub saturates to zero.
module int_calc_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       operation,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             sign,
  output logic             zero,
  output logic             ovf,
  output logic             err
);
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_DIV  = 3'd3;
  localparam logic [2:0] OP_SHL  = 3'd4;
  localparam logic [2:0] OP_LOG2 = 3'd5;
  localparam logic [2:0] OP_POW  = 3'd6;
  localparam logic [2:0] OP_MOD  = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t               state_q;
  logic [2:0]           op_q;
  logic [WIDTH-1:0]     a_q, b_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   acc_q, mcand_q;
  logic [WIDTH-1:0]     mplier_q, rem_q, pow_q;
  // Left-shifting register: dividend bits for div/mod, exponent bits for pow (MSB first).
  logic [WIDTH-1:0]     quo_q;
  logic                 pow_ovf_q;
  logic                 in_ready_q, out_valid_q, sign_q, zero_q, ovf_q, err_q;
  logic [WIDTH-1:0]     sum_q;

  logic [2*WIDTH-1:0]   acc_d, mcand_d, sq_d, ml_d, shl_full_d;
  logic [WIDTH-1:0]     mplier_d, rem_d, quo_d, pow_d, lg_d, res_d;
  logic [WIDTH:0]       rem_sh_d, trial_d;
  logic                 pow_ovf_d, ovf_d, err_d, multi_d, last_d;

  // One iteration of each engine plus the final result selection for the current opcode.
  always_comb begin
    mcand_d  = mcand_q << 1;
    mplier_d = mplier_q >> 1;
    acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    rem_sh_d = {rem_q, quo_q[WIDTH-1]};
    trial_d  = rem_sh_d - {1'b0, b_q};
    if (!trial_d[WIDTH]) begin
      rem_d = trial_d[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = rem_sh_d[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end

    sq_d      = {{WIDTH{1'b0}}, pow_q} * {{WIDTH{1'b0}}, pow_q};
    ml_d      = {{WIDTH{1'b0}}, sq_d[WIDTH-1:0]} * {{WIDTH{1'b0}}, a_q};
    pow_d     = quo_q[WIDTH-1] ? ml_d[WIDTH-1:0] : sq_d[WIDTH-1:0];
    pow_ovf_d = pow_ovf_q | (|sq_d[2*WIDTH-1:WIDTH])
              | (quo_q[WIDTH-1] & (|ml_d[2*WIDTH-1:WIDTH]));

    shl_full_d = {{WIDTH{1'b0}}, a_q} << b_q[CNT_W-1:0];

    lg_d = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (a_q[i]) lg_d = WIDTH'(i);
    end

    multi_d = (op_q == OP_MUL) || (op_q == OP_DIV) || (op_q == OP_MOD) || (op_q == OP_POW);
    last_d  = (cnt_q == CNT_W'(WIDTH - 1));

    res_d = '0;
    ovf_d = 1'b0;
    err_d = 1'b0;
    case (op_q)
      OP_ADD:  {ovf_d, res_d} = {1'b0, a_q} + {1'b0, b_q};
      OP_SUB:  begin res_d = a_q - b_q; ovf_d = (a_q < b_q); end
      OP_MUL:  begin res_d = acc_d[WIDTH-1:0]; ovf_d = |acc_d[2*WIDTH-1:WIDTH]; end
      OP_DIV:  begin res_d = quo_d; err_d = (b_q == '0); end
      OP_MOD:  begin res_d = rem_d; err_d = (b_q == '0); end
      OP_SHL: begin
        if (b_q >= WIDTH'(WIDTH)) begin
          res_d = '0;
          ovf_d = |a_q;
        end else begin
          res_d = shl_full_d[WIDTH-1:0];
          ovf_d = |shl_full_d[2*WIDTH-1:WIDTH];
        end
      end
      OP_LOG2: begin res_d = lg_d; err_d = (a_q == '0); end
      OP_POW:  begin res_d = pow_d; ovf_d = pow_ovf_d; end
      default: res_d = '0;
    endcase
`ifdef INT_CALC_SAT_EN
    if (ovf_d) res_d = (op_q == OP_SUB) ? '0 : '1;
`endif
  end

  // Control FSM, operand capture, engine state and registered result/flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      sign_q      <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      op_q        <= OP_ADD;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      pow_q       <= '0;
      pow_ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_q       <= operation;
            a_q        <= A;
            b_q        <= B;
            cnt_q      <= '0;
            acc_q      <= '0;
            mcand_q    <= {{WIDTH{1'b0}}, A};
            mplier_q   <= B;
            rem_q      <= '0;
            quo_q      <= (operation == OP_POW) ? B : A;
            pow_q      <= WIDTH'(1);
            pow_ovf_q  <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= S_BUSY;
          end
        end
        S_BUSY: begin
          cnt_q     <= cnt_q + CNT_W'(1);
          acc_q     <= acc_d;
          mcand_q   <= mcand_d;
          mplier_q  <= mplier_d;
          rem_q     <= rem_d;
          quo_q     <= quo_d;
          pow_q     <= pow_d;
          pow_ovf_q <= pow_ovf_d;
          if (!multi_d || last_d) begin
            sum_q       <= res_d;
            sign_q      <= res_d[WIDTH-1];
            zero_q      <= (res_d == '0);
            ovf_q       <= ovf_d;
            err_q       <= err_d;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign sign      = sign_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign err       = err_q;

endmodule

// File: tb/tb_int_calc_seq.sv
// tb_int_calc_seq: directed and randomized checks of int_calc_seq against an arithmetic model.
module tb_int_calc_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op_r;
  logic [15:0] a_r, b_r;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        sign, zero, ovf, err;

  int checks   = 0;
  int failures = 0;

  int_calc_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .operation(op_r), .A(a_r), .B(b_r),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .sign(sign), .zero(zero), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference results from plain integer arithmetic.
  function automatic void model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] res, output logic o, output logic e,
                                output int lat);
    longint unsigned p, x;
    int n;
    res = 16'h0; o = 1'b0; e = 1'b0;
    lat = (op == 3'd2 || op == 3'd3 || op == 3'd6 || op == 3'd7) ? 17 : 2;
    case (op)
      3'd0: begin p = 64'(a) + 64'(b); res = 16'(p % 65536); o = (p > 65535); end
      3'd1: begin res = a - b; o = (a < b); end
      3'd2: begin p = 64'(a) * 64'(b); res = 16'(p % 65536); o = (p > 65535); end
      3'd3: begin
        if (b == 16'h0) begin res = 16'hFFFF; e = 1'b1; end
        else res = a / b;
      end
      3'd7: begin
        if (b == 16'h0) begin res = a; e = 1'b1; end
        else res = a % b;
      end
      3'd4: begin
        if (b >= 16) begin res = 16'h0; o = (a != 16'h0); end
        else begin p = 64'(a) << b; res = 16'(p % 65536); o = (p > 65535); end
      end
      3'd5: begin
        if (a == 16'h0) e = 1'b1;
        else begin
          x = 64'(a); n = 0;
          while (x > 1) begin x = x / 2; n++; end
          res = 16'(n);
        end
      end
      default: begin
        p = 1; x = 1;
        for (int i = 0; i < int'(b); i++) begin
          p = (p * 64'(a)) % 65536;
          if (x <= 65535) x = x * 64'(a);
        end
        res = 16'(p);
        o = (x > 65535);
      end
    endcase
`ifdef INT_CALC_SAT_EN
    if (o) res = (op == 3'd1) ? 16'h0 : 16'hFFFF;
`endif
  endfunction

  // Issue one operation from IDLE, check result/flags/latency, then complete the handshake.
  task automatic run_check(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] er;
    logic eo, ee;
    int el, lat;
    model(op, a, b, er, eo, ee, el);
    op_r = op; a_r = a; b_r = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("lat op%0d a=%0h b=%0h", op, a, b), 32'(lat), 32'(el));
    chk($sformatf("sum op%0d a=%0h b=%0h", op, a, b), 32'(sum), 32'(er));
    chk($sformatf("sign op%0d a=%0h b=%0h", op, a, b), 32'(sign), 32'(er[15]));
    chk($sformatf("zero op%0d a=%0h b=%0h", op, a, b), 32'(zero), 32'(er == 16'h0));
    chk($sformatf("ovf op%0d a=%0h b=%0h", op, a, b), 32'(ovf), 32'(eo));
    chk($sformatf("err op%0d a=%0h b=%0h", op, a, b), 32'(err), 32'(ee));
    chk("in_ready_in_done", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("in_ready_after_hs", 32'(in_ready), 32'd1);
    chk("out_valid_after_hs", 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [15:0] held;
    logic [2:0] rop;
    logic [15:0] ra, rb;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op_r = 3'd0; a_r = 16'h0; b_r = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_flags", {28'd0, sign, zero, ovf, err}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases, including the boundary conditions.
    run_check(3'd0, 16'hFFFF, 16'h0002);
    run_check(3'd2, 16'd300, 16'd300);
    run_check(3'd3, 16'd1000, 16'd7);
    run_check(3'd7, 16'd1000, 16'd7);
    run_check(3'd3, 16'd1234, 16'd0);
    run_check(3'd7, 16'd1234, 16'd0);
    run_check(3'd6, 16'd3, 16'd5);
    run_check(3'd6, 16'd0, 16'd0);
    run_check(3'd6, 16'd2, 16'd16);
    run_check(3'd6, 16'd2, 16'd15);
    run_check(3'd6, 16'd256, 16'd2);
    run_check(3'd5, 16'h0400, 16'd0);
    run_check(3'd5, 16'h0000, 16'd0);
    run_check(3'd5, 16'h8000, 16'd0);
    run_check(3'd4, 16'h8001, 16'd1);
    run_check(3'd4, 16'h0001, 16'd16);
    run_check(3'd4, 16'h0000, 16'd20);
    run_check(3'd4, 16'h00FF, 16'd8);
    run_check(3'd1, 16'd3, 16'd5);
    run_check(3'd1, 16'd77, 16'd77);
    run_check(3'd2, 16'hFFFF, 16'hFFFF);
    run_check(3'd3, 16'hFFFF, 16'd1);

    // Backpressure: result held stable, in_valid ignored while DONE.
    op_r = 3'd0; a_r = 16'd40; b_r = 16'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    held = sum;
    chk("bp_sum", 32'(held), 32'd42);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin op_r = 3'd2; a_r = 16'd9; b_r = 16'd9; in_valid = 1'b1; end
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk($sformatf("bp_hold_sum%0d", i), 32'(sum), 32'd42);
      chk($sformatf("bp_hold_flags%0d", i), {28'd0, sign, zero, ovf, err}, 32'd0);
      chk($sformatf("bp_in_ready%0d", i), 32'(in_ready), 32'd0);
      chk($sformatf("bp_out_valid%0d", i), 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_idle_in_ready", 32'(in_ready), 32'd1);
    repeat (20) @(posedge clk);
    #1;
    chk("bp_pulse_ignored", 32'(out_valid), 32'd0);

    // Reset during the eighth BUSY cycle of a multiply.
    op_r = 3'd2; a_r = 16'd300; b_r = 16'd300; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_sum", 32'(sum), 32'd0);
    repeat (20) @(posedge clk);
    #1;
    chk("midrst_no_result", 32'(out_valid), 32'd0);
    run_check(3'd0, 16'd5, 16'd6);

    // Randomized operations.
    for (int n = 0; n < 80; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      if (rop == 3'd6) rb = 16'($urandom_range(0, 20));
      if (rop == 3'd6 && n % 3 == 0) ra = 16'($urandom_range(0, 5));
      if (rop == 3'd4 && n % 2 == 0) rb = 16'($urandom_range(0, 20));
      if ((rop == 3'd3 || rop == 3'd7) && n % 5 == 0) rb = 16'h0;
      if ((rop == 3'd3 || rop == 3'd7) && n % 5 == 1) rb = 16'($urandom_range(1, 300));
      if (rop == 3'd2 && n % 2 == 0) begin
        ra = 16'($urandom_range(0, 255));
        rb = 16'($urandom_range(0, 255));
      end
      if (rop == 3'd5 && n % 4 == 0) ra = 16'h0;
      run_check(rop, ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
